// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO UART/perf-counter responder: register offsets,
// status bit positions and the address-region nibble.
package mmio_pkg;

    localparam logic [3:0] MMIO_REGION    = 4'h8;

    localparam logic [7:0] MMIO_STATUS    = 8'h00;
    localparam logic [7:0] MMIO_RX_DATA   = 8'h04;
    localparam logic [7:0] MMIO_TX_DATA   = 8'h08;
    localparam logic [7:0] MMIO_CYCLE_CNT = 8'h10;
    localparam logic [7:0] MMIO_INST_CNT  = 8'h14;
    localparam logic [7:0] MMIO_CNT_RST   = 8'h18;

    localparam int STAT_TX_EMPTY = 0;
    localparam int STAT_RX_VALID = 1;

endpackage

// File: rtl/mmio_rx_fifo.sv
// Synchronous byte FIFO for the UART receive path. Push is ignored when full and
// pop when empty; a simultaneous push and pop leaves the count unchanged.
module mmio_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage is not reset; empty/full come only from the count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_responder.sv
// MMIO responder for the 0x8xxx_xxxx window: UART TX holding register, RX FIFO and
// optional cycle/instret counters (enabled by defining MMIO_PERF_COUNTERS_EN).
module mmio_uart_responder
    import mmio_pkg::*;
#(
    parameter int          RX_FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE     = {MMIO_REGION, 28'h0}
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_we,
    input  logic        req_re,
    output logic [31:0] rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        inst_retire
);

    localparam int AW = $clog2(RX_FIFO_DEPTH);

    logic        hit;
    logic [7:0]  offset;
    logic        rx_push;
    logic        rx_pop;
    logic [7:0]  rx_head;
    logic        rx_full;
    logic        rx_empty;
    logic [AW:0] rx_count;
    logic [31:0] rd_val;
    logic [31:0] cycle_cnt;
    logic [31:0] inst_cnt;

    assign hit    = (req_addr[31:28] == MMIO_BASE[31:28]);
    assign offset = req_addr[7:0];

    assign rx_ready = !rx_full;
    assign rx_push  = rx_valid && !rx_full;
    // An empty-FIFO read returns 0 and must not pop a byte pushed in the same cycle.
    assign rx_pop   = req_re && hit && (offset == MMIO_RX_DATA) && !rx_empty;

    mmio_rx_fifo #(
        .DEPTH (RX_FIFO_DEPTH),
        .WIDTH (8)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (rx_data),
        .head  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

`ifdef MMIO_PERF_COUNTERS_EN
    logic cnt_clr;
    assign cnt_clr = hit && (req_we != 4'b0) && (offset == MMIO_CNT_RST);

    always_ff @(posedge clk) begin
        if (!rst || cnt_clr) begin
            cycle_cnt <= '0;
            inst_cnt  <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (inst_retire) inst_cnt <= inst_cnt + 32'd1;
        end
    end
`else
    assign cycle_cnt = '0;
    assign inst_cnt  = '0;
`endif

    always_comb begin
        rd_val = '0;
        case (offset)
            MMIO_STATUS: begin
                rd_val[STAT_TX_EMPTY] = !tx_valid;
                rd_val[STAT_RX_VALID] = !rx_empty;
            end
            MMIO_RX_DATA:   rd_val = rx_empty ? 32'd0 : {24'd0, rx_head};
            MMIO_CYCLE_CNT: rd_val = cycle_cnt;
            MMIO_INST_CNT:  rd_val = inst_cnt;
            default:        rd_val = '0;
        endcase
    end

    // rdata only updates on a load so it holds across idle cycles.
    always_ff @(posedge clk) begin
        if (!rst)        rdata <= '0;
        else if (req_re) rdata <= hit ? rd_val : 32'd0;
    end

    // A write landing on the handshake cycle sees tx_valid=1 and is dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else if (tx_valid) begin
            if (tx_ready) tx_valid <= 1'b0;
        end else if (hit && req_we[0] && (offset == MMIO_TX_DATA)) begin
            tx_valid <= 1'b1;
            tx_data  <= req_wdata[7:0];
        end
    end

    logic unused;
    assign unused = &{1'b0, req_addr[27:8], req_wdata[31:8], req_we, inst_retire,
                      rx_count, MMIO_BASE[27:0]};

endmodule

// File: tb/tb_mmio_uart_responder.sv
// Directed self-checking bench for mmio_uart_responder; counter checks depend on
// whether MMIO_PERF_COUNTERS_EN is defined.
module tb_mmio_uart_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_we = '0;
    logic        req_re = 1'b0;
    logic [31:0] rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        inst_retire = 1'b0;

    int checks = 0;
    int errors = 0;

    mmio_uart_responder dut (
        .clk         (clk),
        .rst         (rst),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_we      (req_we),
        .req_re      (req_re),
        .rdata       (rdata),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .inst_retire (inst_retire)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] A_STAT = 32'h8000_0000;
    localparam logic [31:0] A_RX   = 32'h8000_0004;
    localparam logic [31:0] A_TX   = 32'h8000_0008;
    localparam logic [31:0] A_CYC  = 32'h8000_0010;
    localparam logic [31:0] A_INST = 32'h8000_0014;
    localparam logic [31:0] A_CRST = 32'h8000_0018;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled at the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        req_addr = addr;
        req_re   = 1'b1;
        tick();
        req_re   = 1'b0;
        data     = rdata;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        req_addr  = addr;
        req_wdata = data;
        req_we    = 4'hF;
        tick();
        req_we    = 4'h0;
    endtask

    task automatic push(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    logic [31:0] d;

    initial begin
        // Reset
        repeat (3) tick();
        rst = 1'b1;
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
        rd(A_STAT, d); chk("rst_status", d, 32'h1);

        // TX byte held while tx_ready low
        wr(A_TX, 32'h41);
        chk("tx_valid_set", {31'd0, tx_valid}, 32'd1);
        repeat (10) tick();
        chk("tx_valid_held", {31'd0, tx_valid}, 32'd1);
        chk("tx_data_held", {24'd0, tx_data}, 32'h41);
        rd(A_STAT, d); chk("status_tx_full", d, 32'h0);
        wr(A_TX, 32'h55);
        chk("tx_drop_full", {24'd0, tx_data}, 32'h41);
        tx_ready = 1'b1; tick(); tx_ready = 1'b0;
        chk("tx_handshake", {31'd0, tx_valid}, 32'd0);
        rd(A_STAT, d); chk("status_tx_empty", d, 32'h1);

        // Write on the handshake cycle is dropped
        wr(A_TX, 32'h62);
        chk("tx_load2", {24'd0, tx_data}, 32'h62);
        tx_ready = 1'b1; wr(A_TX, 32'h63); tx_ready = 1'b0;
        chk("tx_hs_write_drop", {31'd0, tx_valid}, 32'd0);
        chk("tx_hs_data", {24'd0, tx_data}, 32'h62);

        // rdata holds across idle cycles
        rd(A_STAT, d);
        repeat (3) tick();
        chk("rdata_hold", rdata, 32'h1);

        // RX fill to full, drain in order, underflow read
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
        chk("rx_full_ready", {31'd0, rx_ready}, 32'd0);
        rd(A_STAT, d); chk("status_rx", d, 32'h3);
        push(8'hEE);
        for (int i = 0; i < 8; i++) begin
            rd(A_RX, d); chk($sformatf("rx_drain%0d", i), d, 32'h10 + i);
        end
        rd(A_RX, d); chk("rx_underflow", d, 32'h0);
        rd(A_STAT, d); chk("status_rx_empty", d, 32'h1);

        // Move pointers to 6 so three entries straddle the wrap
        for (int i = 0; i < 6; i++) push(8'h00);
        for (int i = 0; i < 6; i++) rd(A_RX, d);
        push(8'hA0); push(8'hA1); push(8'hA2);
        for (int i = 0; i < 4; i++) begin
            rx_data  = 8'hB0 + 8'(i);
            rx_valid = 1'b1;
            rd(A_RX, d);
            rx_valid = 1'b0;
            chk($sformatf("pp_pop%0d", i), d, (i < 3) ? (32'hA0 + i) : 32'hB0);
        end
        chk("pp_ready", {31'd0, rx_ready}, 32'd1);
        for (int i = 1; i < 4; i++) begin
            rd(A_RX, d); chk($sformatf("pp_drain%0d", i), d, 32'hB0 + i);
        end
        rd(A_RX, d); chk("pp_empty", d, 32'h0);

        // Push into empty FIFO while reading: returns 0, byte kept
        rx_data = 8'h7E; rx_valid = 1'b1;
        rd(A_RX, d);
        rx_valid = 1'b0;
        chk("push_empty_read", d, 32'h0);
        rd(A_RX, d); chk("push_empty_kept", d, 32'h7E);

        // Unmapped offset and non-hit addresses
        wr(32'h8000_0020, 32'hFF);
        rd(32'h8000_0020, d); chk("unmapped_read", d, 32'h0);
        wr(32'h0000_0008, 32'h99);
        chk("nonhit_tx", {31'd0, tx_valid}, 32'd0);
        push(8'h33);
        rd(32'h0000_0004, d); chk("nonhit_read", d, 32'h0);
        rd(A_STAT, d); chk("nonhit_no_pop", d, 32'h3);

        // Mid-operation reset drops TX and RX state
        wr(A_TX, 32'h5A);
        rst = 1'b0; tick(); rst = 1'b1;
        chk("midrst_tx", {31'd0, tx_valid}, 32'd0);
        chk("midrst_rdata", rdata, 32'h0);
        rd(A_STAT, d); chk("midrst_status", d, 32'h1);

        // Counters: reset, 100 cycles, 50 retirements
        rst = 1'b0; tick(); rst = 1'b1;
        for (int i = 0; i < 100; i++) begin
            inst_retire = (i % 2 == 0);
            tick();
        end
        inst_retire = 1'b0;
`ifdef MMIO_PERF_COUNTERS_EN
        rd(A_CYC, d);  chk("cycle_cnt", d, 32'd100);
        rd(A_INST, d); chk("inst_cnt", d, 32'd50);
        wr(A_CRST, 32'h1);
        rd(A_CYC, d);  chk("cycle_clr", d, 32'd0);
        rd(A_INST, d); chk("inst_clr", d, 32'd0);
`else
        rd(A_CYC, d);  chk("cycle_off", d, 32'd0);
        rd(A_INST, d); chk("inst_off", d, 32'd0);
        wr(A_CRST, 32'h1);
        rd(A_STAT, d); chk("crst_ignored", d, 32'h1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmio_uart_responder.md
Name: mmio_uart_responder

Overview:
Memory-mapped I/O responder answering Riscv151 load/store requests in the 0x8xxx_xxxx address space. Bridges CPU stores and loads to the on-chip UART ready/valid byte interfaces, with a TX holding register and an RX FIFO. Provides cycle and retired-instruction performance counters. Sits beside dmem/bios_mem on the execute-stage address/data bus; read data returns on the same 1-cycle latency as dmem.

Parameters:
RX_FIFO_DEPTH, 8, RX byte FIFO entries; power of 2, range 2..64
MMIO_BASE, 32'h8000_0000, base address of the register window; compared on bits [31:28]

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-low reset
req_addr  in  32  byte address from ALU output, execute stage
req_wdata  in  32  store data, already lane-shifted
req_we  in  4  store byte enables; nonzero = write
req_re  in  1  load strobe, execute stage
rdata  out  32  load data, valid the cycle after req_re
tx_data  out  8  byte to UART transmitter
tx_valid  out  1  tx_data valid
tx_ready  in  1  UART transmitter accepts byte
rx_data  in  8  byte from UART receiver
rx_valid  in  1  rx_data valid
rx_ready  out  1  responder accepts rx byte
inst_retire  in  1  one instruction retired this cycle

Behaviour:
- Reset (rst==0 at a clk edge): rdata=0, tx_valid=0, tx_data=0, rx_ready=1, FIFO empty, both counters=0. A mid-operation reset drops any pending TX byte and all FIFO contents.
- Hit: req_addr[31:28]==MMIO_BASE[31:28]. Offset = req_addr[7:0]. Non-hits and unmapped offsets read as 0, and writes to them are ignored.
- Register map:
  - 0x00 status (RO): bit0 = TX holding register empty; bit1 = RX FIFO non-empty; others 0.
  - 0x04 RX data (RO): {24'b0, head byte}. A read pops the FIFO.
  - 0x08 TX data (WO): store with req_we[0]==1 loads req_wdata[7:0].
  - 0x10 cycle counter (RO).
  - 0x14 instruction counter (RO).
  - 0x18 counter reset (WO): any nonzero req_we clears both counters.
- Read latency: rdata registered from values sampled in request cycle N; valid in N+1. rdata holds its value until the next req_re.
- TX handshake:
  - TX data write while holding register empty: tx_data loaded, tx_valid=1 from N+1.
  - tx_valid stays 1 and tx_data stays stable until the cycle where tx_valid && tx_ready; tx_valid=0 the next cycle.
  - Write while full: dropped, no state change.
  - Write in the same cycle as the handshake completes: dropped. Status is sampled pre-edge, so software must poll.
- RX FIFO:
  - Push when rx_valid && rx_ready.
  - rx_ready = !full, combinational from registered count.
  - Pop on RX data read when non-empty.
  - Read when empty returns 0, no pop, no underflow.
  - Push and pop in the same cycle: count unchanged, returned data is the pre-edge head.
  - Push into an empty FIFO concurrent with a read: read returns 0, byte is retained.
  - Pointers wrap modulo RX_FIFO_DEPTH; count is log2(depth)+1 bits.
- Counters:
  - 32-bit, wrap 0xFFFF_FFFF -> 0.
  - Cycle counter increments every cycle; instruction counter increments when inst_retire.
  - Clear write takes priority: both counters are 0 the cycle after a clear, regardless of increments.
  - A read in the same cycle as a clear returns the pre-clear value.
- Simultaneous req_re and nonzero req_we are never issued by the core. If they occur, both are performed.

Optional Feature:
MMIO_PERF_COUNTERS_EN.
- Defined: counters at 0x10/0x14/0x18 behave as above.
- Undefined: no counter registers are built; 0x10/0x14 read 0, 0x18 writes are ignored, inst_retire is unused.

Decomposition:
- Shared package mmio_pkg holds:
  - offset constants (MMIO_STATUS, MMIO_RX_DATA, MMIO_TX_DATA, MMIO_CYCLE_CNT, MMIO_INST_CNT, MMIO_CNT_RST);
  - status bit indices (STAT_TX_EMPTY, STAT_RX_VALID);
  - MMIO region nibble.
- One sub-module: mmio_rx_fifo. Parameterised sync FIFO with push/pop/full/empty/head/count; it owns pointer wrap and simultaneous push/pop.

Test Plan:
- Reset: hold rst=0 for 3 cycles -> rdata=0, tx_valid=0, rx_ready=1; status read returns 0x1.
- TX byte:
  - store 0x41 to 0x8000_0008 with tx_ready=0 -> tx_valid=1, tx_data=0x41 held 10 cycles, status read returns 0x0;
  - raise tx_ready 1 cycle -> tx_valid=0;
  - second store while full is dropped.
- RX FIFO fill:
  - push 8 bytes 0x10..0x17 -> rx_ready=0 after 8th, status=0x3;
  - 8 reads of 0x8000_0004 return 0x10..0x17 in order;
  - a 9th read returns 0 and status=0x1.
- Simultaneous push/pop with 3 entries across wrap boundary -> count stays 3, order preserved, no loss.
- Counters (macro defined):
  - after reset run 100 cycles with inst_retire every other cycle -> reads of 0x10/0x14 return 100±read offset and 50;
  - store to 0x18 -> next reads near 0.
- Macro undefined: 0x10/0x14 read 0; unmapped offset 0x20 reads 0 and ignores writes.
